// File: rtl/lcd_hd44780_ctrl.sv
// Write-only sequencer for an HD44780-compatible character LCD (8-bit bus).
// After reset it waits for LCD power-up, then plays the fixed instruction-mode
// init sequence. After that it accepts one instruction/character per
// valid/ready handshake. For each byte it generates the setup, enable-pulse,
// hold and execution-wait timing. The busy flag is never read, so RW is tied low.
//
// Ports:
//   clk_clk                          system clock
//   reset_reset_n                    asynchronous reset, active low
//   in_valid / in_ready              request handshake (accept when both high)
//   in_rs, in_data                   0 = instruction, 1 = character; byte code
//   busy                             high whenever not idle
//   init_done                        sticky, set when the init sequence ends
//   lcd_display_readdata             LCD data bus
//   lcd_rs_writeresponsevalid_n      LCD RS
//   lcd_rw_writeresponsevalid_n      LCD RW (always 0)
//   lcd_enable_writeresponsevalid_n  LCD E
module lcd_hd44780_ctrl #(
    parameter int unsigned T_PWRUP   = 750000,
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN_HIGH = 12,
    parameter int unsigned T_HOLD    = 4,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_RSTWAIT = 205000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] lcd_display_readdata,
    output logic       lcd_rs_writeresponsevalid_n,
    output logic       lcd_rw_writeresponsevalid_n,
    output logic       lcd_enable_writeresponsevalid_n
);

    localparam int unsigned CW = 24;
    localparam int unsigned IW = 3;
    localparam logic [IW-1:0] INIT_LAST = IW'(6);

    // Terminal counts: a phase of N cycles ends when the counter reaches N-1
    localparam logic [CW-1:0] L_PWRUP   = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] L_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN_HIGH = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] L_HOLD    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_CMD     = CW'(T_CMD - 1);
    localparam logic [CW-1:0] L_CLEAR   = CW'(T_CLEAR - 1);
    localparam logic [CW-1:0] L_RSTWAIT = CW'(T_RSTWAIT - 1);

    typedef enum logic [2:0] {
        PWRUP,
        SETUP,
        EN_HI,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idx, idx_n;
    logic [7:0]      data_q, data_n;
    logic            rs_q, rs_n;
    logic            done_q, done_n;
    logic            e_q, ready_q, busy_q;
    logic [CW-1:0]   wait_lim;

    // Init instruction ROM (all RS=0)
    function automatic logic [7:0] init_rom(input logic [IW-1:0] i);
        logic [7:0] v;
        case (i)
            3'd0, 3'd1, 3'd2: v = 8'h30;
            3'd3:             v = 8'h38;
            3'd4:             v = 8'h0C;
            3'd5:             v = 8'h01;
            default:          v = 8'h06;
        endcase
        return v;
    endfunction

    // State, counter, latched byte and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= PWRUP;
            cnt     <= '0;
            idx     <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            done_q  <= 1'b0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            data_q  <= data_n;
            rs_q    <= rs_n;
            done_q  <= done_n;
            // Outputs track the state being entered so they align with it
            e_q     <= (state_n == EN_HI);
            ready_q <= (state_n == IDLE);
            busy_q  <= (state_n != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        data_n  = data_q;
        rs_n    = rs_q;
        done_n  = done_q;

        // First 0x30 needs the long reset wait; clear/home need the long exec wait
        if (!done_q && (idx == '0))
            wait_lim = L_RSTWAIT;
        else if (!rs_q && (data_q[7:2] == 6'd0))
            wait_lim = L_CLEAR;
        else
            wait_lim = L_CMD;

        case (state)
            PWRUP: begin
                if (cnt == L_PWRUP) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    idx_n   = '0;
                    rs_n    = 1'b0;
                    data_n  = init_rom('0);
                end
            end
            SETUP: begin
                if (cnt == L_SETUP) begin
                    state_n = EN_HI;
                    cnt_n   = '0;
                end
            end
            EN_HI: begin
                if (cnt == L_EN_HIGH) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                if (cnt == L_HOLD) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (cnt == wait_lim) begin
                    cnt_n = '0;
                    if (!done_q && (idx != INIT_LAST)) begin
                        idx_n   = idx + IW'(1);
                        data_n  = init_rom(idx + IW'(1));
                        state_n = SETUP;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (in_valid && ready_q) begin
                    rs_n    = in_rs;
                    data_n  = in_data;
                    state_n = SETUP;
                end
            end
            default: begin
                state_n = PWRUP;
                cnt_n   = '0;
            end
        endcase
    end

    assign in_ready                        = ready_q;
    assign busy                            = busy_q;
    assign init_done                       = done_q;
    assign lcd_display_readdata            = data_q;
    assign lcd_rs_writeresponsevalid_n     = rs_q;
    assign lcd_rw_writeresponsevalid_n     = 1'b0;
    assign lcd_enable_writeresponsevalid_n = e_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl using the small-parameter build.
// Expected LCD bytes go into a scoreboard queue when stimulus is issued. A
// monitor pops one entry on every rising E and checks the pulse contents and width.
module tb_lcd_hd44780_ctrl;

    localparam int unsigned P_PWRUP   = 20;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_EN_HIGH = 3;
    localparam int unsigned P_HOLD    = 2;
    localparam int unsigned P_CMD     = 5;
    localparam int unsigned P_CLEAR   = 10;
    localparam int unsigned P_RSTWAIT = 8;
    localparam int          INIT_CYC  = 112;
    localparam int          SPACING   = 1 + 2 + 3 + 2 + 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] cur_exp = 9'h000;
    logic       e_prev = 1'b0;
    int         hi_cnt = 0;

    logic [7:0] init_tbl [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_hd44780_ctrl #(
        .T_PWRUP  (P_PWRUP),
        .T_SETUP  (P_SETUP),
        .T_EN_HIGH(P_EN_HIGH),
        .T_HOLD   (P_HOLD),
        .T_CMD    (P_CMD),
        .T_CLEAR  (P_CLEAR),
        .T_RSTWAIT(P_RSTWAIT)
    ) dut (
        .clk_clk                        (clk),
        .reset_reset_n                  (rst_n),
        .in_valid                       (in_valid),
        .in_rs                          (in_rs),
        .in_data                        (in_data),
        .in_ready                       (in_ready),
        .busy                           (busy),
        .init_done                      (init_done),
        .lcd_display_readdata           (lcd_data),
        .lcd_rs_writeresponsevalid_n    (lcd_rs),
        .lcd_rw_writeresponsevalid_n    (lcd_rw),
        .lcd_enable_writeresponsevalid_n(lcd_e)
    );

    always #5 clk = ~clk;

    // Pulse monitor: pop on rising E, check RS/data through the pulse and its width
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0;
            hi_cnt = 0;
        end else begin
            checks++;
            if (lcd_rw !== 1'b0) begin
                failures++;
                $display("FAIL rw_low: got %b required 0", lcd_rw);
            end
            if (lcd_e && !e_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got rs=%b data=%h required no pulse", lcd_rs, lcd_data);
                end else begin
                    cur_exp = exp_q.pop_front();
                    if ({lcd_rs, lcd_data} !== cur_exp) begin
                        failures++;
                        $display("FAIL pulse_byte: got %h required %h", {lcd_rs, lcd_data}, cur_exp);
                    end
                end
                hi_cnt = 1;
            end else if (lcd_e) begin
                hi_cnt++;
                checks++;
                if ({lcd_rs, lcd_data} !== cur_exp) begin
                    failures++;
                    $display("FAIL pulse_stable: got %h required %h", {lcd_rs, lcd_data}, cur_exp);
                end
            end else if (e_prev) begin
                checks++;
                if (hi_cnt != int'(P_EN_HIGH)) begin
                    failures++;
                    $display("FAIL e_width: got %0d required %0d", hi_cnt, P_EN_HIGH);
                end
            end
            e_prev = lcd_e;
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: got in_ready=%b required 1", tag, in_ready);
        end
    endtask

    // Issue one request from IDLE; returns at the negedge after the handshake edge
    task automatic send(input logic rs, input logic [7:0] d);
        wait_idle("send");
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        exp_q.push_back({rs, d});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Release reset and check the complete init sequence timing
    task automatic release_and_check_init(input string tag);
        int  first_rise;
        int  ready_at;
        logic prev_e;
        logic early_done;
        exp_q.delete();
        foreach (init_tbl[i]) exp_q.push_back({1'b0, init_tbl[i]});
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'hAA;
        first_rise = -1;
        ready_at   = -1;
        prev_e     = 1'b0;
        early_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (lcd_e && !prev_e && first_rise < 0) first_rise = n;
            prev_e = lcd_e;
            if (in_ready) begin
                ready_at = n;
                break;
            end
            if (init_done || !busy) early_done = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (first_rise != int'(P_PWRUP + P_SETUP)) begin
            failures++;
            $display("FAIL %s_first_e: got cycle %0d required %0d", tag, first_rise, P_PWRUP + P_SETUP);
        end
        checks++;
        if (ready_at != INIT_CYC) begin
            failures++;
            $display("FAIL %s_ready_cycle: got %0d required %0d", tag, ready_at, INIT_CYC);
        end
        checks++;
        if (early_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_early_status: got done/idle before ready required none", tag);
        end
        checks++;
        if ({init_done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL %s_done_status: got done=%b busy=%b required 1 0", tag, init_done, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_init_pulses: got %0d unsent required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_data, lcd_rs, lcd_rw, lcd_e, in_ready, busy, init_done} !== {8'h00, 6'b000_010}) begin
            failures++;
            $display("FAIL reset_values: got data=%h rs=%b rw=%b e=%b rdy=%b busy=%b done=%b required 00 0 0 0 0 1 0",
                     lcd_data, lcd_rs, lcd_rw, lcd_e, in_ready, busy, init_done);
        end
        release_and_check_init("init");
    endtask

    task automatic test_char_write();
        logic [11:0] got, exp;
        send(1'b1, 8'h41);
        for (int m = 0; m <= 12; m++) begin
            got = {lcd_rs, lcd_data, lcd_e, in_ready, busy, 1'b0};
            if (m < 12) exp = {1'b1, 8'h41, (m >= 2 && m <= 4), 1'b0, 1'b1, 1'b0};
            else        exp = {1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL char_write_m%0d: got %h required %h", m, got, exp);
            end
            if (m < 12) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_clear_wait();
        logic [7:0] cmds [3] = '{8'h01, 8'h02, 8'h80};
        int         waits [3] = '{10, 10, 5};
        int fall, rdy;
        logic saw_e;
        for (int k = 0; k < 3; k++) begin
            send(1'b0, cmds[k]);
            fall = -1;
            rdy = -1;
            saw_e = 1'b0;
            for (int m = 0; m < 100; m++) begin
                if (fall < 0 && saw_e && !lcd_e) fall = m;
                if (lcd_e) saw_e = 1'b1;
                if (in_ready) begin
                    rdy = m;
                    break;
                end
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if (rdy - fall != int'(P_HOLD) + waits[k]) begin
                failures++;
                $display("FAIL wait_after_%h: got %0d required %0d", cmds[k], rdy - fall, int'(P_HOLD) + waits[k]);
            end
            checks++;
            if (rdy != 7 + waits[k]) begin
                failures++;
                $display("FAIL total_%h: got %0d required %0d", cmds[k], rdy, 7 + waits[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pend[$];
        int         hs_t[$];
        logic       hs;
        wait_idle("b2b");
        pend = '{8'h48, 8'h69, 8'h21};
        foreach (pend[i]) exp_q.push_back({1'b1, pend[i]});
        for (int n = 0; n < 200 && pend.size() > 0; n++) begin
            in_valid = 1'b1;
            in_rs    = 1'b1;
            in_data  = pend[0];
            hs = in_ready;
            @(posedge clk);
            if (hs) begin
                hs_t.push_back(n);
                void'(pend.pop_front());
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle("b2b_end");
        checks++;
        if (hs_t.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d required 3", hs_t.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (hs_t[i] - hs_t[i-1] != SPACING) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: got %0d required %0d", i, hs_t[i] - hs_t[i-1], SPACING);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d unsent required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        send(1'b1, 8'h55);
        n = 0;
        while (!lcd_e && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (lcd_e !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach_en: got e=%b required 1", lcd_e);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({lcd_e, busy, init_done, in_ready} !== 4'b0100) begin
            failures++;
            $display("FAIL mid_async_reset: got e/busy/done/rdy=%b required 0100", {lcd_e, busy, init_done, in_ready});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_rs, lcd_data} !== 9'h000) begin
            failures++;
            $display("FAIL mid_reset_bus: got %h required 000", {lcd_rs, lcd_data});
        end
        release_and_check_init("reinit");
    endtask

    task automatic test_data_hold();
        int bad;
        send(1'b0, 8'h80);
        bad = 0;
        for (int m = 0; m < 100 && !in_ready; m++) begin
            in_data = 8'($urandom);
            in_rs   = 1'($urandom);
            if ({lcd_rs, lcd_data} !== 9'h080) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        for (int m = 0; m < 3; m++) begin
            in_data = 8'($urandom);
            if ({lcd_rs, lcd_data} !== 9'h080) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL data_hold: got %0d disturbed cycles required 0", bad);
        end
        send(1'b0, 8'h0C);
        checks++;
        if ({lcd_rs, lcd_data} !== 9'h00C) begin
            failures++;
            $display("FAIL data_next: got %h required 00c", {lcd_rs, lcd_data});
        end
        wait_idle("hold_end");
    endtask

    initial begin
        test_reset();
        test_char_write();
        test_clear_wait();
        test_back_to_back();
        test_reset_mid();
        test_data_hold();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Write-only sequencer for the HD44780-compatible character LCD on the lcd_* pads: 8-bit data bus, RS, RW and enable.
- After reset it runs the power-up wait and the fixed instruction-mode init sequence by itself.
- It then accepts one command or character per valid/ready handshake from the Nios-side register block and generates the setup, enable-pulse, hold and execution-wait timing.
- The LCD busy flag is never read; RW is tied low.

Parameters:
- T_PWRUP, 750000: cycles of power-up wait before the first init instruction (15 ms at 50 MHz).
- T_SETUP, 4: cycles RS/data are stable with enable low before the pulse.
- T_EN_HIGH, 12: cycles enable is high.
- T_HOLD, 4: cycles RS/data are held after enable falls.
- T_CMD, 2000: execution wait after a normal instruction or data write (40 us).
- T_CLEAR, 82000: execution wait after clear or home, i.e. RS=0 and data[7:2]==0 (1.64 ms).
- T_RSTWAIT, 205000: execution wait after the first init 0x30 (4.1 ms).
- All parameters are ≥1 and <2^24. Counter width is 24 bits.

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset_n  in  1  asynchronous reset, active low.
- in_valid  in  1  request valid.
- in_rs  in  1  0 = instruction, 1 = character data.
- in_data  in  8  instruction or character code.
- in_ready  out  1  request accepted on a clock edge where in_valid and in_ready are both high.
- busy  out  1  high whenever the block is not in IDLE.
- init_done  out  1  sticky high once the init sequence has finished.
- lcd_display_readdata  out  8  LCD data bus.
- lcd_rs_writeresponsevalid_n  out  1  LCD RS.
- lcd_rw_writeresponsevalid_n  out  1  LCD RW, constant 0.
- lcd_enable_writeresponsevalid_n  out  1  LCD E.

Behaviour:
- Reset values (asynchronous, held while reset is low): state PWRUP, counter 0, init index 0.
  - lcd data 0x00, RS 0, RW 0, E 0.
  - in_ready 0, busy 1, init_done 0.
- All outputs are registered.
- States: PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE.
- PWRUP: lasts T_PWRUP cycles, then loads init entry 0 and goes to SETUP.
- Init ROM, RS=0 for every entry, 7 entries: 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06.
  - Wait after entry 0 is T_RSTWAIT.
  - Wait after 0x01 is T_CLEAR.
  - Wait after all other entries is T_CMD.
- Phase timing:
  - SETUP: E=0, RS/data driven, exactly T_SETUP cycles.
  - EN_HI: E=1, exactly T_EN_HIGH cycles.
  - HOLD: E=0, exactly T_HOLD cycles.
  - WAIT: E=0, exactly the selected wait length.
  - RS and data stay constant from SETUP entry to WAIT exit.
- WAIT exit:
  - If in init and the index is below 6: increment the index and return to SETUP.
  - If in init and the index is 6: go to IDLE and set init_done.
  - Otherwise: go to IDLE.
- IDLE: in_ready=1, busy=0.
  - On a handshake, latch in_rs/in_data into the RS/data registers and go to SETUP on that edge.
  - in_ready drops the following cycle.
  - Wait selection uses the latched values: RS=0 and data[7:2]==0 selects T_CLEAR, else T_CMD.
- in_ready is 0 in every state except IDLE. A requester holding in_valid while busy is served when IDLE is next entered; nothing is dropped or queued internally.
- IDLE lasts at least 1 cycle, so back-to-back requests are spaced 1+T_SETUP+T_EN_HIGH+T_HOLD+wait cycles apart.
- Input changes outside a handshake edge are ignored.
- Reset asserted mid-operation: E drops immediately, all state clears, and the full power-up/init sequence reruns after release.
- Cycle numbering in the tests: cycle 1 is the first rising edge with reset_reset_n high.

Test Plan:
Small-parameter build used by all scenarios: T_PWRUP=20, T_SETUP=2, T_EN_HIGH=3, T_HOLD=2, T_CMD=5, T_CLEAR=10, T_RSTWAIT=8.
1. Init sequence after reset release -> seven E pulses, each exactly 3 cycles high, with data 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06 and RS=0.
   - First E rise follows 20+2 cycles of PWRUP/SETUP.
   - init_done and in_ready rise after 112 cycles.
   - in_ready stays 0 before that even with in_valid=1.
2. Character write of RS=1, data 0x41 in IDLE -> in_ready falls the next cycle.
   - RS=1 and data=0x41 are stable for 2+3+2+5 cycles, with E high in cycles 3-5 of that window.
   - Returns to IDLE and in_ready=1 after 12 cycles.
3. Instruction 0x01, then 0x02, then 0x80 -> waits of 10, 10 and 5 cycles respectively after E falls (plus the 2-cycle hold).
4. in_valid held continuously with 3 queued characters 'H','i','!' -> three handshakes exactly 13 cycles apart, no loss or duplication.
   - RW stays 0 throughout.
5. reset_reset_n pulsed low during EN_HI of a user write -> E=0, busy=1, init_done=0 immediately (asynchronously).
   - After release, the full 112-cycle init reruns before in_ready returns.
6. in_data changed while busy, with no handshake -> LCD data bus holds the latched value until the next accepted request.
